// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and default width for the serial operand loader.
package serial_pkg;
    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} ser_state_t;
    localparam int SER_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-load, right-shift register with zero fill; bit 0 is the serial output.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             lsb_o
);
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else if (load_i) data_q <= d_i;
        else if (shift_i) data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
    assign lsb_o = data_q[0];
endmodule

// File: rtl/serial_operand_loader.sv
// serial_operand_loader: captures an operand pair, clears the serial adder, streams bits LSB-first.
// SER_CARRY_FLUSH_EN adds a trailing zero pair so the adder shifts its carry out on F.
module serial_operand_loader
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             last,
    output logic             sa_rst,
    output logic             done
);
`ifdef SER_CARRY_FLUSH_EN
    localparam int CW = $clog2(WIDTH + 2);
    localparam int LAST_IDX = WIDTH;
`else
    localparam int CW = $clog2(WIDTH + 1);
    localparam int LAST_IDX = WIDTH - 1;
`endif
    ser_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic a_bit_q, b_bit_q, bit_valid_q, last_q, sa_rst_q, done_q;
    logic load, shift, is_last, a_lsb, b_lsb;
    assign load    = (state_q == IDLE) && in_valid;
    assign shift   = (state_q == SHIFT);
    assign is_last = (cnt_q == CW'(LAST_IDX));
    piso_shift #(.WIDTH(WIDTH)) u_sh_a (
        .clk(clk), .rst_n(rst_n), .load_i(load), .shift_i(shift), .d_i(a_in), .lsb_o(a_lsb)
    );
    piso_shift #(.WIDTH(WIDTH)) u_sh_b (
        .clk(clk), .rst_n(rst_n), .load_i(load), .shift_i(shift), .d_i(b_in), .lsb_o(b_lsb)
    );
    // Outputs are registered from the current state, so each lags its state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_bit_q     <= 1'b0;
            b_bit_q     <= 1'b0;
            bit_valid_q <= 1'b0;
            last_q      <= 1'b0;
            sa_rst_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sa_rst_q    <= (state_q == CLR);
            bit_valid_q <= shift;
            a_bit_q     <= shift & a_lsb;
            b_bit_q     <= shift & b_lsb;
            last_q      <= shift & is_last;
            done_q      <= (state_q == DONE);
            case (state_q)
                IDLE: if (in_valid) begin
                    state_q <= CLR;
                    cnt_q   <= '0;
                end
                CLR: state_q <= SHIFT;
                SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_last) state_q <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = rst_n && (state_q == IDLE);
    assign a_bit     = a_bit_q;
    assign b_bit     = b_bit_q;
    assign bit_valid = bit_valid_q;
    assign last      = last_q;
    assign sa_rst    = sa_rst_q;
    assign done      = done_q;
endmodule

// File: tb/tb_serial_operand_loader.sv
// tb_serial_operand_loader: random and directed words checked against cycle timing and a serial adder model.
module tb_serial_operand_loader;
    localparam int W = 8;
`ifdef SER_CARRY_FLUSH_EN
    localparam int LK = W + 2;
`else
    localparam int LK = W + 1;
`endif
    localparam int DK = LK + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic in_ready, a_bit, b_bit, bit_valid, last, sa_rst, done;
    logic f, cout;
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    serial_operand_loader #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .a_bit(a_bit), .b_bit(b_bit), .bit_valid(bit_valid),
        .last(last), .sa_rst(sa_rst), .done(done)
    );

    // Downstream serial adder: registered sum bit and carry, cleared by sa_rst | ~rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) {cout, f} <= 2'b00;
        else if (sa_rst) {cout, f} <= 2'b00;
        else {cout, f} <= 2'(a_bit) + 2'(b_bit) + 2'(cout);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input logic rdy);
        check("q_ready", in_ready, rdy);
        check("q_outs", {a_bit, b_bit, bit_valid, last, sa_rst, done}, 6'b0);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle. hold keeps in_valid high with junk.
    task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int t;
        logic [W:0] exp_sum, got_sum;
        logic ea, eb;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", in_ready, 1'b1);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            a_in = W'($urandom);
            b_in = W'($urandom);
        end else in_valid = 1'b0;
        exp_sum = {1'b0, a} + {1'b0, b};
        got_sum = '0;
        for (int k = 0; k <= DK; k++) begin
            @(negedge clk);
            ea = (k >= 2 && k <= W + 1) ? a[k-2] : 1'b0;
            eb = (k >= 2 && k <= W + 1) ? b[k-2] : 1'b0;
            check("sa_rst", sa_rst, k == 1);
            check("bit_valid", bit_valid, k >= 2 && k <= LK);
            check("a_bit", a_bit, ea);
            check("b_bit", b_bit, eb);
            check("last", last, k == LK);
            check("done", done, k == DK);
            check("in_ready", in_ready, k == DK);
            if (k >= 3) got_sum[k-3] = f;
            if (k == DK) begin
`ifdef SER_CARRY_FLUSH_EN
                check("sum", got_sum, exp_sum);
                check("cout", cout, 1'b0);
`else
                check("sum", got_sum[W-1:0], exp_sum[W-1:0]);
                check("cout", cout, exp_sum[W]);
`endif
            end
        end
    endtask

    initial begin
        #1;
        check("rst_ready", in_ready, 1'b0);
        check_quiet(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_quiet(1'b1);
        end
        run_word(8'h5A, 8'h3C, 1'b0);
        @(negedge clk);
        run_word(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        run_word(8'h01, 8'h01, 1'b1);
        run_word(8'h80, 8'h80, 1'b0);
        @(negedge clk);
        check_quiet(1'b1);
        // Abort a word with reset in its fifth cycle.
        a_in = 8'hA5;
        b_in = 8'h5A;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_bv", bit_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_quiet(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 14; k++) begin
            check_quiet(1'b1);
            @(negedge clk);
        end
        run_word(8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < 24; i++) begin
            bit hold;
            hold = (i < 23) && ($urandom_range(0, 2) == 0);
            run_word(W'($urandom), W'($urandom), hold);
            if (!hold) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                check("gap_ready", in_ready, 1'b1);
            end
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
